// File: rtl/wb_pkg.sv
// Widths and the 29-bit completion entry shared by the writeback arbiter and its buffers.
// Entry layout {wrt, phy, data, indx} matches the FIFO storage word one-to-one.
package wb_pkg;
   localparam int PHY_W     = 6;
   localparam int DATA_W    = 16;
   localparam int INDX_W    = 6;
   localparam int ALU_DEPTH = 2;

   typedef struct packed {
      logic              wrt;
      logic [PHY_W-1:0]  phy;
      logic [DATA_W-1:0] data;
      logic [INDX_W-1:0] indx;
   } wb_entry_t;
endpackage

// File: rtl/wb_fifo.sv
// Power-of-two circular buffer of wb_entry_t; head is combinational, count/pointers registered.
// Push is accepted when not full or when popping in the same cycle; clr empties it synchronously.
module wb_fifo
   import wb_pkg::*;
#(
   parameter int DEPTH = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic                   clr,
   input  logic                   push,
   input  logic                   pop,
   input  wb_entry_t              din,
   output wb_entry_t              head,
   output logic [$clog2(DEPTH):0] count,
   output logic                   full,
   output logic                   empty
);
   localparam int AW = $clog2(DEPTH);

   wb_entry_t     mem [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic          do_push;
   logic          do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_pop  = pop && !empty;
   assign do_push = push && (!full || do_pop);
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else if (clr) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + AW'(1);
         if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
         if (do_push && !do_pop)      count <= count + (AW+1)'(1);
         else if (!do_push && do_pop) count <= count - (AW+1)'(1);
      end
   end

   // Storage needs no reset: only entries behind a valid count are ever read.
   always_ff @(posedge clk) begin
      if (do_push && !clr) mem[wr_ptr] <= din;
   end
endmodule

// File: rtl/wb_arbiter.sv
// Merges buffered load and ALU completions onto one RF write port; 2-cycle latency, stalls when buffers near full.
// ALU has priority; defining WB_STARVE_EN lets a load preempt after STARVE_MAX lost cycles.
module wb_arbiter
   import wb_pkg::*;
#(
   parameter int LD_DEPTH   = 4,
   parameter int STARVE_MAX = 3
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flsh,
   input  logic              vld_ld,
   input  logic              reg_wrt_ld,
   input  logic [PHY_W-1:0]  phy_addr_ld,
   input  logic [DATA_W-1:0] data_ld,
   input  logic [INDX_W-1:0] indx_ld,
   output logic              stll_ld,
   input  logic              vld_alu,
   input  logic              reg_wrt_alu,
   input  logic [PHY_W-1:0]  phy_addr_alu,
   input  logic [DATA_W-1:0] data_alu,
   input  logic [INDX_W-1:0] indx_alu,
   output logic              stll_alu,
   output logic              rf_we,
   output logic [PHY_W-1:0]  rf_addr,
   output logic [DATA_W-1:0] rf_data,
   output logic              cmp_vld,
   output logic [INDX_W-1:0] cmp_indx,
   output logic              ovf_err
);
   localparam int LCW = $clog2(LD_DEPTH) + 1;
   localparam int ACW = $clog2(ALU_DEPTH) + 1;

   wb_entry_t      ld_in, alu_in, ld_head, alu_head, win;
   logic [LCW-1:0] ld_cnt;
   logic [ACW-1:0] alu_cnt;
   logic           ld_full, ld_empty, alu_full, alu_empty;
   logic           grant_ld, grant_alu, ld_drop, starved;

   assign ld_in  = '{wrt: reg_wrt_ld, phy: phy_addr_ld, data: data_ld, indx: indx_ld};
   assign alu_in = '{wrt: reg_wrt_alu, phy: phy_addr_alu, data: data_alu, indx: indx_alu};

   wb_fifo #(.DEPTH(LD_DEPTH)) u_ld_fifo (
      .clk(clk), .rst(rst), .clr(flsh), .push(vld_ld && !flsh), .pop(grant_ld),
      .din(ld_in), .head(ld_head), .count(ld_cnt), .full(ld_full), .empty(ld_empty)
   );

   wb_fifo #(.DEPTH(ALU_DEPTH)) u_alu_fifo (
      .clk(clk), .rst(rst), .clr(flsh), .push(vld_alu && !flsh), .pop(grant_alu),
      .din(alu_in), .head(alu_head), .count(alu_cnt), .full(alu_full), .empty(alu_empty)
   );

`ifdef WB_STARVE_EN
   localparam int SW = (STARVE_MAX < 1) ? 1 : $clog2(STARVE_MAX + 1);
   logic [SW-1:0] starve_cnt;

   assign starved = (starve_cnt == SW'(STARVE_MAX));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst)                             starve_cnt <= '0;
      else if (flsh || ld_empty || grant_ld) starve_cnt <= '0;
      else if (!starved)                    starve_cnt <= starve_cnt + SW'(1);
   end
`else
   assign starved = 1'b0;
`endif

   assign grant_ld  = !flsh && !ld_empty && (alu_empty || starved);
   assign grant_alu = !flsh && !alu_empty && !grant_ld;
   assign win       = grant_ld ? ld_head : alu_head;
   assign ld_drop   = vld_ld && !flsh && ld_full && !grant_ld;

   // One slot of slack beyond the stall threshold covers the producer's reaction cycle.
   assign stll_ld  = (ld_cnt >= LCW'(LD_DEPTH - 1));
   assign stll_alu = alu_full || (alu_cnt >= ACW'(1));

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rf_we    <= 1'b0;
         rf_addr  <= '0;
         rf_data  <= '0;
         cmp_vld  <= 1'b0;
         cmp_indx <= '0;
         ovf_err  <= 1'b0;
      end else begin
         rf_we   <= 1'b0;
         cmp_vld <= 1'b0;
         if (grant_ld || grant_alu) begin
            rf_we    <= win.wrt;
            cmp_vld  <= 1'b1;
            rf_addr  <= win.phy;
            rf_data  <= win.data;
            cmp_indx <= win.indx;
         end
         if (ld_drop) ovf_err <= 1'b1;
      end
   end
endmodule
